xc_sha256_schedule: RTL and testbench

Sequential SHA-256 message-schedule expander: accepts one 512-bit block as sixteen 32-bit words over a valid/ready load port, then streams the expanded schedule words W[0]..W[NWORDS-1] over a valid/ready output port. It is the consumer of the lightweight sigma0/sigma1 transforms. It sits beside the xcrypto SHA-256 instruction logic as the message-side feeder for an iterative round engine.

---
 rtl/xc_sha256_pkg.sv | 19 +
 rtl/xc_sha256_schedule_if.sv | 23 ++
 rtl/xc_sha256_sched_word.sv | 14 +
 rtl/xc_sha256_schedule.sv | 83 ++++++++
 tb/tb_xc_sha256_schedule.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/xc_sha256_pkg.sv
// xc_sha256_pkg: shared FSM encodings and SHA-256 schedule sigma functions.
// Contents: state_t (IDLE/LOAD/EMIT), ror32, sigma0, sigma1.
package xc_sha256_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } state_t;
   localparam int WIN_N = 16;
   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
   endfunction
endpackage

// File: rtl/xc_sha256_schedule_if.sv
// xc_sha256_schedule_if: load and schedule-stream handshake bundle.
// Signals: flush, ld_valid/ld_ready/ld_data (message load),
// w_valid/w_ready/w_data/w_idx/w_last (schedule output).
// slave = the expander, master = the producer/consumer side.
interface xc_sha256_schedule_if;
   logic        flush;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_data;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [5:0]  w_idx;
   logic        w_last;
   modport master (
      output flush, ld_valid, ld_data, w_ready,
      input  ld_ready, w_valid, w_data, w_idx, w_last
   );
   modport slave (
      input  flush, ld_valid, ld_data, w_ready,
      output ld_ready, w_valid, w_data, w_idx, w_last
   );
endinterface

// File: rtl/xc_sha256_sched_word.sv
// xc_sha256_sched_word: combinational next schedule word from the window taps.
// Ports: w0_i/w1_i/w9_i/w14_i = win[0], win[1], win[9], win[14];
// nxt_o = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0] mod 2^32.
module xc_sha256_sched_word
   import xc_sha256_pkg::*;
(
   input  logic [31:0] w0_i,
   input  logic [31:0] w1_i,
   input  logic [31:0] w9_i,
   input  logic [31:0] w14_i,
   output logic [31:0] nxt_o
);
   assign nxt_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;
endmodule

// File: rtl/xc_sha256_schedule.sv
// xc_sha256_schedule: loads sixteen message words, then streams W[0]..W[NWORDS-1].
// Ports: g_clk, g_resetn (async active-low), bus (slave modport of
// xc_sha256_schedule_if). All bus outputs come straight from registers.
module xc_sha256_schedule
   import xc_sha256_pkg::*;
#(
   parameter int NWORDS = 64
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   xc_sha256_schedule_if.slave   bus
);
   localparam logic [5:0] LAST = 6'(NWORDS - 1);
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [5:0]  t_q;
   logic        ld_ready_q;
   logic        w_valid_q;
   logic        w_last_q;
   logic [31:0] win_q [WIN_N];
   logic [31:0] nxt_d;
   logic        ld_hs;
   logic        w_hs;
   assign ld_hs        = bus.ld_valid & ld_ready_q;
   assign w_hs         = w_valid_q & bus.w_ready;
   assign bus.ld_ready = ld_ready_q;
   assign bus.w_valid  = w_valid_q;
   assign bus.w_data   = win_q[0];
   assign bus.w_idx    = t_q;
   assign bus.w_last   = w_last_q;
   xc_sha256_sched_word u_word (
      .w0_i  (win_q[0]),
      .w1_i  (win_q[1]),
      .w9_i  (win_q[9]),
      .w14_i (win_q[14]),
      .nxt_o (nxt_d)
   );
   always_ff @(posedge g_clk or negedge g_resetn)
      if (!g_resetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         t_q        <= '0;
         ld_ready_q <= 1'b1;
         w_valid_q  <= 1'b0;
         w_last_q   <= 1'b0;
      end else if (bus.flush) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         t_q        <= '0;
         ld_ready_q <= 1'b1;
         w_valid_q  <= 1'b0;
         w_last_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_LOAD:
               if (ld_hs) begin
                  // cnt wraps 15 -> 0 as the 16th word lands, ready for the next block
                  cnt_q      <= cnt_q + 4'd1;
                  state_q    <= cnt_q == 4'd15 ? ST_EMIT : ST_LOAD;
                  ld_ready_q <= cnt_q != 4'd15;
                  w_valid_q  <= cnt_q == 4'd15;
               end
            ST_EMIT:
               if (w_hs) begin
                  state_q    <= t_q == LAST ? ST_IDLE : ST_EMIT;
                  t_q        <= t_q == LAST ? 6'd0 : t_q + 6'd1;
                  ld_ready_q <= t_q == LAST;
                  w_valid_q  <= t_q != LAST;
                  w_last_q   <= t_q != LAST && (t_q + 6'd1) == LAST;
               end
            default: state_q <= ST_IDLE;
         endcase
      end
   // The window shifts on every accepted load or output word; win[15] takes
   // the fresh message word while loading and the expanded word while emitting.
   always_ff @(posedge g_clk or negedge g_resetn)
      if (!g_resetn) begin
         for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
      end else if (!bus.flush && (ld_hs || w_hs)) begin
         for (int i = 0; i < WIN_N - 1; i++) win_q[i] <= win_q[i+1];
         win_q[WIN_N-1] <= w_hs ? nxt_d : bus.ld_data;
      end
endmodule

// File: tb/tb_xc_sha256_schedule.sv
// tb_xc_sha256_schedule: scoreboard bench for the SHA-256 schedule expander.
module tb_xc_sha256_schedule;
   localparam int NW = 64;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   xc_sha256_schedule_if bus ();
   xc_sha256_schedule #(.NWORDS(NW)) dut (
      .g_clk    (clk),
      .g_resetn (rst_n),
      .bus      (bus)
   );
   typedef struct {
      logic [5:0]  idx;
      logic [31:0] data;
      logic        last;
   } exp_t;
   exp_t        exp_q [$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] got [64];
   logic [31:0] abc [16];
   logic [31:0] zro [16];
   logic [31:0] rnd [16];
   function automatic logic [31:0] m_rot(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction
   function automatic logic [31:0] m_s0(input logic [31:0] x);
      return m_rot(x, 7) ^ m_rot(x, 18) ^ {3'b000, x[31:3]};
   endfunction
   function automatic logic [31:0] m_s1(input logic [31:0] x);
      return m_rot(x, 17) ^ m_rot(x, 19) ^ {10'd0, x[31:10]};
   endfunction
   task automatic push_expected(input logic [31:0] blk [16]);
      logic [31:0] w [64];
      for (int t = 0; t < 64; t++)
         w[t] = t < 16 ? blk[t] : m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
      for (int t = 0; t < NW; t++)
         exp_q.push_back('{idx: 6'(t), data: w[t], last: (t == NW - 1)});
   endtask
   task automatic load(input logic [31:0] blk [16], input int gap_pct, input int nw);
      int i = 0;
      int cyc = 0;
      while (i < nw && cyc < 400) begin
         @(negedge clk);
         cyc++;
         vectors++;
         if (bus.ld_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_state word=%0d ld_ready=%b w_valid=%b required 1/0", i, bus.ld_ready, bus.w_valid);
         end
         bus.ld_valid = $urandom_range(99) >= gap_pct;
         bus.ld_data  = bus.ld_valid ? blk[i] : $urandom();
         if (bus.ld_valid && bus.ld_ready) i++;
      end
      if (i < nw) begin
         miscompares++;
         $display("FAIL load_timeout accepted=%0d required %0d", i, nw);
      end
   endtask
   task automatic drain(input int stall_pct, input int limit);
      int          n = 0;
      int          cyc = 0;
      logic        stalled = 1'b0;
      logic [31:0] held = '0;
      exp_t        e;
      while (n < limit && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.ld_valid = 1'($urandom_range(1));
         bus.ld_data  = $urandom();
         vectors++;
         if (bus.w_valid !== 1'b1 || bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL emit_state n=%0d w_valid=%b ld_ready=%b required 1/0", n, bus.w_valid, bus.ld_ready);
         end
         if (stalled) begin
            vectors++;
            if (bus.w_data !== held) begin
               miscompares++;
               $display("FAIL stall_hold n=%0d w_data=%h required %h", n, bus.w_data, held);
            end
         end
         bus.w_ready = $urandom_range(99) >= stall_pct;
         if (bus.w_valid && bus.w_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL scoreboard_empty w_idx=%0d w_data=%h required no output", bus.w_idx, bus.w_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.w_data !== e.data || bus.w_idx !== e.idx || bus.w_last !== e.last) begin
                  miscompares++;
                  $display("FAIL w_word idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                           bus.w_idx, bus.w_data, bus.w_last, e.idx, e.data, e.last);
               end
            end
            got[bus.w_idx] = bus.w_data;
            n++;
         end
         stalled = bus.w_valid && !bus.w_ready;
         held    = bus.w_data;
      end
      if (n < limit) begin
         miscompares++;
         $display("FAIL drain_timeout words=%0d required %0d", n, limit);
      end
   endtask
   task automatic finish_check(input string name);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.w_ready  = 1'b0;
      vectors++;
      if (bus.ld_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.w_last !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_end ld_ready=%b w_valid=%b w_last=%b pending=%0d required 1/0/0/0",
                  name, bus.ld_ready, bus.w_valid, bus.w_last, exp_q.size());
      end
   endtask
   task automatic check_reset_values(input string name);
      vectors++;
      if (bus.ld_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 ||
          bus.w_idx !== 6'd0 || bus.w_last !== 1'b0) begin
         miscompares++;
         $display("FAIL %s ld_ready=%b w_valid=%b w_data=%h w_idx=%0d w_last=%b required 1/0/0/0/0",
                  name, bus.ld_ready, bus.w_valid, bus.w_data, bus.w_idx, bus.w_last);
      end
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("post_reset");
   endtask
   task automatic test_abc();
      push_expected(abc);
      load(abc, 0, 16);
      drain(0, NW);
      finish_check("abc");
      vectors++;
      if (got[16] !== 32'h61626380 || got[17] !== 32'h000f0000) begin
         miscompares++;
         $display("FAIL abc_w16_w17 got=%h %h required 61626380 000f0000", got[16], got[17]);
      end
      vectors++;
      if (got[0] !== 32'h61626380 || got[15] !== 32'h00000018) begin
         miscompares++;
         $display("FAIL abc_echo got=%h %h required 61626380 00000018", got[0], got[15]);
      end
   endtask
   task automatic test_zero();
      push_expected(zro);
      load(zro, 0, 16);
      drain(0, NW);
      finish_check("zero");
   endtask
   task automatic test_backpressure();
      push_expected(abc);
      load(abc, 0, 16);
      drain(50, NW);
      finish_check("stall");
   endtask
   task automatic test_load_gaps();
      push_expected(abc);
      load(abc, 50, 16);
      drain(0, NW);
      finish_check("gaps");
   endtask
   task automatic test_flush();
      push_expected(abc);
      load(abc, 0, 16);
      drain(0, 20);
      @(negedge clk);
      bus.ld_valid = 1'b1;
      vectors++;
      if (bus.w_valid !== 1'b1 || bus.w_idx !== 6'd20) begin
         miscompares++;
         $display("FAIL flush_pre w_valid=%b w_idx=%0d required 1/20", bus.w_valid, bus.w_idx);
      end
      bus.flush   = 1'b1;
      bus.w_ready = 1'b1;
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.w_ready  = 1'b0;
      bus.ld_valid = 1'b0;
      vectors++;
      if (bus.w_valid !== 1'b0 || bus.ld_ready !== 1'b1 || bus.w_idx !== 6'd0) begin
         miscompares++;
         $display("FAIL flush_post w_valid=%b ld_ready=%b w_idx=%0d required 0/1/0", bus.w_valid, bus.ld_ready, bus.w_idx);
      end
      exp_q.delete();
      for (int i = 0; i < 16; i++) rnd[i] = $urandom();
      push_expected(rnd);
      load(rnd, 0, 16);
      drain(20, NW);
      finish_check("after_flush");
   endtask
   task automatic test_reset_midload();
      load(abc, 0, 7);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_values("midload_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) rnd[i] = $urandom();
      push_expected(rnd);
      load(rnd, 30, 16);
      drain(30, NW);
      finish_check("after_reset");
   endtask
   initial begin
      bus.flush    = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.w_ready  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         abc[i] = '0;
         zro[i] = '0;
      end
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;
      test_reset();
      test_abc();
      test_zero();
      test_backpressure();
      test_load_gaps();
      test_flush();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
